// File: rtl/wb_pkg.sv
// Shared types and constants for the write-buffer drain engine.
package wb_pkg;

    // Default geometry of the write-buffer entry and the memory bus.
    localparam int WB_WIDTH  = 59;
    localparam int WB_ADDR_W = 58;
    localparam int WB_BEAT_W = 64;
    localparam int WB_BEATS  = 8;

    // Derived constants for the default geometry.
    localparam int INV_BIT = WB_WIDTH - 1;
    localparam int LINE_W  = WB_BEATS * WB_BEAT_W;
    localparam int CNT_W   = $clog2(WB_BEATS);

    // Drain sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        REQ  = 3'd3,
        BEAT = 3'd4,
        ACK  = 3'd5,
        POP  = 3'd6
    } wb_state_t;

    // Decoded view of a FIFO entry (default geometry).
    typedef struct packed {
        logic                 inv;
        logic [WB_ADDR_W-1:0] addr;
    } wb_entry_t;

    // Split a raw FIFO word into its inv flag and line address.
    function automatic wb_entry_t unpack_entry(input logic [WB_WIDTH-1:0] raw);
        wb_entry_t e;
        e.inv  = raw[INV_BIT];
        e.addr = raw[WB_ADDR_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/wb_beat_serializer.sv
// Holds one cache line and hands it out one bus beat at a time, beat 0 first.
module wb_beat_serializer
    import wb_pkg::*;
#(
    parameter int BEAT_W = WB_BEAT_W,
    parameter int BEATS  = WB_BEATS
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_i,
    input  logic [BEATS*BEAT_W-1:0]   line_i,
    input  logic                      advance_i,
    output logic [BEAT_W-1:0]         beat_o,
    output logic                      last_o,
    output logic                      done_o
);

    localparam int CNT_BITS = $clog2(BEATS);
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(BEATS - 1);

    logic [BEATS*BEAT_W-1:0]     line_q;
    logic [CNT_BITS-1:0]         cnt_q;
    logic [BEATS-1:0][BEAT_W-1:0] beats_w;

    // Slice the stored line into an indexable array of beats.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beats_w[gi] = line_q[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    assign beat_o = beats_w[cnt_q];
    assign last_o = (cnt_q == LAST_IDX);
    assign done_o = advance_i && last_o;

    // Capture the line when the data array returns it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q <= '0;
        end else if (load_i) begin
            line_q <= line_i;
        end
    end

    // Step the beat index on each accepted beat; wrap to 0 after the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (advance_i) begin
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/wb_drain.sv
// Consumer end of the write-buffer CAM FIFO: turns each head entry into a
// memory-bus writeback or invalidate and pops it only once the bus acks.
module wb_drain
    import wb_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int BEAT_W = WB_BEAT_W,
    parameter int BEATS  = WB_BEATS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fifo_empty,
    input  logic [WIDTH-1:0]         fifo_data,
    output logic                     fifo_pop,
    output logic                     arr_rd_en,
    output logic [ADDR_W-1:0]        arr_rd_addr,
    input  logic [BEATS*BEAT_W-1:0]  arr_rd_data,
    output logic                     bus_req_valid,
    input  logic                     bus_req_ready,
    output logic [ADDR_W-1:0]        bus_req_addr,
    output logic                     bus_req_inv,
    output logic                     bus_wdata_valid,
    input  logic                     bus_wdata_ready,
    output logic [BEAT_W-1:0]        bus_wdata,
    output logic                     bus_wdata_last,
    input  logic                     bus_ack,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     busy
);

    localparam int INV_POS = WIDTH - 1;

    wb_state_t           state_q, state_d;
    logic                inv_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                flush_pending_q, flush_pending_d;

    logic                ser_load;
    logic                ser_advance;
    logic [BEAT_W-1:0]   ser_beat;
    logic                ser_last;
    logic                ser_done;

    wb_beat_serializer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (ser_load),
        .line_i    (arr_rd_data),
        .advance_i (ser_advance),
        .beat_o    (ser_beat),
        .last_o    (ser_last),
        .done_o    (ser_done)
    );

    // State register, head-entry latch and flush tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            inv_q           <= 1'b0;
            addr_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            // Latch the head so later pushes cannot disturb the transaction.
            if (state_q == IDLE && !fifo_empty) begin
                inv_q  <= fifo_data[INV_POS];
                addr_q <= fifo_data[ADDR_W-1:0];
            end
        end
    end

    // Flush completes on the first idle, empty cycle; a new flush pulse re-arms it.
    always_comb begin
        flush_done      = (state_q == IDLE) && fifo_empty && flush_pending_q;
        flush_pending_d = (flush_pending_q && !flush_done) || flush;
    end

    // Next-state logic and all bus/array/FIFO strobes; addresses and data
    // are forced to zero outside the state that drives them.
    always_comb begin
        state_d         = state_q;
        fifo_pop        = 1'b0;
        arr_rd_en       = 1'b0;
        arr_rd_addr     = '0;
        bus_req_valid   = 1'b0;
        bus_req_addr    = '0;
        bus_req_inv     = 1'b0;
        bus_wdata_valid = 1'b0;
        bus_wdata       = '0;
        bus_wdata_last  = 1'b0;
        ser_load        = 1'b0;
        ser_advance     = 1'b0;
        busy            = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = fifo_data[INV_POS] ? REQ : RD;
                end
            end
            RD: begin
                arr_rd_en   = 1'b1;
                arr_rd_addr = addr_q;
                state_d     = RDW;
            end
            RDW: begin
                ser_load = 1'b1;
                state_d  = REQ;
            end
            REQ: begin
                bus_req_valid = 1'b1;
                bus_req_addr  = addr_q;
                bus_req_inv   = inv_q;
                if (bus_req_ready) begin
                    state_d = inv_q ? ACK : BEAT;
                end
            end
            BEAT: begin
                bus_wdata_valid = 1'b1;
                bus_wdata       = ser_beat;
                bus_wdata_last  = ser_last;
                ser_advance     = bus_wdata_ready;
                if (ser_done) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (bus_ack) begin
                    state_d = POP;
                end
            end
            POP: begin
                fifo_pop = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
